// File: rtl/arb_mux_reg.sv
// arb_mux_reg: N-way valid/ready arbiter (fixed priority or round-robin) feeding a one-entry output register
module arb_mux_reg #(
    parameter int WIDTH = 32,
    parameter int N = 8,
    parameter int SEL_W = 3,
    parameter bit RR = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    input  logic               out_ready
);
    localparam logic [SEL_W:0] NW = (SEL_W+1)'(N);
    logic [SEL_W-1:0] rr_ptr, g, off;
    logic [SEL_W:0]   sum;
    logic [2*N-1:0]   vv;
    logic             found, can_load, load;
    // Rotate requests so rr_ptr sits at bit 0; the lowest set bit is the winner's offset from rr_ptr.
    always_comb begin
        vv = {in_valid, in_valid} >> rr_ptr;
        off = '0;
        for (int k = N - 1; k >= 0; k--)
            off = vv[k] ? SEL_W'(k) : off;
        sum = {1'b0, rr_ptr} + {1'b0, off};
        g = sum >= NW ? SEL_W'(sum - NW) : SEL_W'(sum);
    end
    assign found    = |in_valid;
    assign can_load = !out_valid || out_ready;
    assign load     = found && can_load;
    assign in_ready = (load && !rst) ? N'(1) << g : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(g)*WIDTH +: WIDTH];
            out_sel   <= g;
            rr_ptr    <= (RR && int'(g) != N - 1) ? g + 1'b1 : '0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_arb_mux_reg.sv
// tb_arb_mux_reg: three configurations (RR/N=8, fixed/N=8, RR/N=5) on shared stimulus, queue scoreboards
module tb_arb_mux_reg;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         out_ready = 1'b0;
  logic [7:0]   in_valid = '0;
  logic [255:0] in_data = '0;
  int           n_tests = 0;
  int           n_fail = 0;
  always #5 clk = ~clk;
  function automatic int pick(logic [7:0] v, int p, int n);
    for (int k = 0; k < n; k++)
      if (v[(p + k) % n]) return (p + k) % n;
    return -1;
  endfunction
  generate
    for (genvar c = 0; c < 3; c++) begin : u
      localparam int NN = (c == 2) ? 5 : 8;
      localparam bit RRC = (c != 1);
      logic [NN-1:0] rdy;
      logic          ov;
      logic [31:0]   od;
      logic [2:0]    os;
      logic [34:0]   q[$];
      logic [34:0]   last = '0;
      bit            full = 0;
      int            ptr = 0;
      arb_mux_reg #(.WIDTH(32), .N(NN), .SEL_W(3), .RR(RRC)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[NN-1:0]), .in_data(in_data[NN*32-1:0]),
        .in_ready(rdy), .out_valid(ov), .out_data(od), .out_sel(os),
        .out_ready(out_ready)
      );
      always @(posedge clk) begin
        int g;
        if (rst) begin
          full = 0;
          ptr = 0;
          last = '0;
        end else begin
          g = pick(in_valid, ptr, NN);
          if ((!full || out_ready) && g >= 0) begin
            last = {g[2:0], in_data[g*32 +: 32]};
            q.push_back(last);
            full = 1;
            if (RRC) ptr = (g + 1) % NN;
          end else if (out_ready) begin
            full = 0;
          end
        end
      end
      always @(negedge clk) begin
        int g;
        logic [7:0] er;
        g = pick(in_valid, ptr, NN);
        er = (!rst && (!full || out_ready) && g >= 0) ? 8'(1 << g) : 8'h00;
        n_tests++;
        if (8'(rdy) !== er) begin
          n_fail++;
          $display("FAIL cfg%0d in_ready: got %h exp %h", c, rdy, er);
        end
        n_tests++;
        if (ov !== full) begin
          n_fail++;
          $display("FAIL cfg%0d out_valid: got %b exp %b", c, ov, full);
        end
        n_tests++;
        if (full) begin
          if (q.size() == 0 || {os, od} !== q[0]) begin
            n_fail++;
            $display("FAIL cfg%0d word: got sel %0d data %h exp %h", c, os, od,
                     q.size() ? q[0] : 35'h0);
          end
          if (out_ready && q.size() != 0) void'(q.pop_front());
        end else if ({os, od} !== last) begin
          n_fail++;
          $display("FAIL cfg%0d held: got sel %0d data %h exp %h", c, os, od, last);
        end
        if (rst) q.delete();
      end
    end
  endgenerate
  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    for (int i = 0; i < 8; i++) in_data[i*32 +: 32] = 32'h100 + i;
    in_valid = 8'hFF;
    out_ready = 1'b1;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(12);
    in_valid = 8'b1010_0100;
    step(6);
    in_valid = 8'b0001_0010;
    step(8);
    in_valid = 8'hFF;
    out_ready = 1'b0;
    step(4);
    out_ready = 1'b1;
    step(3);
    out_ready = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(2);
    out_ready = 1'b1;
    step(2);
    for (int t = 0; t < 3000; t++) begin
      in_valid = 8'($urandom);
      for (int i = 0; i < 8; i++) in_data[i*32 +: 32] = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      step(1);
    end
    rst = 1'b0;
    step(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
